ddr3_frame_arbiter: RTL
=======================

DDR3_FRAME_ARBITER -- requirements
Module: ddr3_frame_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 64, full burst length in words (1..255).
REQ-002 Parameter RD_FIFO_DEPTH, default 1024, capacity in words of the downstream read FIFO.
REQ-003 Parameter BANK_SIZE, default 28'h0100000, word offset between frame bank 0 and bank 1.
REQ-004 Port clk  in  1  single clock for the whole block; all logic is on its rising edge.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port calib_done  in  1  DDR3 calibration complete; no request is issued while low.
REQ-007 Port wr_frame_start  in  1  one-cycle pulse marking the start of a camera frame (pos_vsync, already in clk domain).
REQ-008 Port rd_frame_start  in  1  one-cycle pulse marking the start of an LCD frame.
REQ-009 Port addr_max  in  28  words per frame (h_pixel*v_pixel); sampled continuously.
REQ-010 Port wr_fifo_cnt  in  11  words held in the camera write FIFO.
REQ-011 Port rd_fifo_cnt  in  11  words held in the LCD read FIFO.
REQ-012 Port wr_req / rd_req  out  1 each  burst request strobes; at most one is high at a time.
REQ-013 Port req_addr  out  28  burst start word address; req_len  out  8  burst length in words.
REQ-014 Port req_ack  in  1  DDR3 controller has accepted the pending request.
REQ-015 Port burst_done  in  1  one-cycle pulse when the accepted burst has completed.
REQ-016 Port wr_bank / rd_bank  out  1 each  current write/read frame bank; frame_ready  out  1  a full frame has been written.

Function
REQ-017 FSM states IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT; reset state IDLE.
REQ-018 wr_rem = addr_max - wr_off; wr_len = min(BURST_LEN, wr_rem); rd_rem and rd_len are defined likewise from rd_off.
REQ-019 Write is eligible when calib_done, wr_rem>0 and wr_fifo_cnt >= wr_len.
REQ-020 Read is eligible when calib_done, frame_ready, rd_rem>0 and rd_fifo_cnt + rd_len <= RD_FIFO_DEPTH, computed 12 bits wide.
REQ-021 In IDLE with one request eligible, go to that side's REQ state; with both eligible, grant the side not granted last (last_grant resets to read, so write wins first).
REQ-022 On entry to a REQ state, register req_addr = bank*BANK_SIZE + off (28-bit, wraps modulo 2^28) and req_len = len; hold wr_req/rd_req high and both fields stable until req_ack.
REQ-023 REQ state + req_ack: drop the strobe next cycle and go to WAIT; latency from IDLE decision to strobe is 1 cycle.
REQ-024 WAIT + burst_done: off += req_len, update last_grant, return to IDLE; the next grant can occur on the cycle after.
REQ-025 burst_done outside a WAIT state is ignored; req_ack outside a REQ state is ignored.
REQ-026 wr_frame_start in IDLE, or when the pending flag is applied on the IDLE return: if wr_off >= addr_max and addr_max != 0, toggle wr_bank and set frame_ready; in all cases wr_off <= 0.
REQ-027 wr_frame_start during WR_REQ/WR_WAIT sets wr_pend; the in-flight burst completes normally and REQ-026 is applied on the IDLE return. A second pulse while pending is merged.
REQ-028 rd_frame_start applied in IDLE, or pended during RD_REQ/RD_WAIT in the same way: rd_bank <= ~wr_bank if frame_ready, else rd_bank unchanged; rd_off <= 0.
REQ-029 Write and read frame starts applied in the same cycle: the write action takes effect first, so rd_bank selects the newly completed bank.
REQ-030 Frame starts in the other side's states are not pended; they are applied immediately, since the offsets are independent.
REQ-031 A partial write frame (wr_off<addr_max at wr_frame_start) is discarded and the bank is not toggled.
REQ-032 addr_max=0 means no side is ever eligible. An addr_max reduction below an offset gives rem<=0, so that side is not eligible.

Reset
REQ-033 rst_n low asynchronously forces: state IDLE, wr_req=0, rd_req=0, req_addr=0, req_len=0, wr_off=rd_off=0, wr_bank=0, rd_bank=0, frame_ready=0, wr_pend=rd_pend=0, last_grant=read.
REQ-034 Reset mid-burst abandons the burst without any completion handshake; after release, behaviour is identical to power-up.

Verification
REQ-035 BURST_LEN=64, addr_max=200, wr_fifo_cnt=300, calib_done=1, single-cycle ack/done -> writes at 0,64,128,192 with lengths 64,64,64,8; then idle.
REQ-036 Both sides eligible continuously -> grants alternate W,R,W,R; wr_req and rd_req are never high together.
REQ-037 Full frame written, then wr_frame_start -> wr_bank=1, frame_ready=1, next write at 0x0100000; rd_frame_start then -> rd_bank=0.
REQ-038 wr_frame_start during WR_WAIT at wr_off=64 -> burst finishes, then wr_off=0 with bank unchanged; next write at bank base +0.
REQ-039 rd_fifo_cnt=961, RD_FIFO_DEPTH=1024, BURST_LEN=64 -> no rd_req; at 960 -> rd_req within 2 cycles.
REQ-040 rst_n pulsed low during RD_WAIT -> all outputs at reset values immediately; first post-reset grant is write.

Source files
------------

// File: rtl/ddr3_frame_arbiter.sv
// Arbitrates DDR3 burst requests between the camera write path and LCD read path,
// double-buffering whole frames across two banks.
module ddr3_frame_arbiter #(
   parameter int          BURST_LEN     = 64,
   parameter int          RD_FIFO_DEPTH = 1024,
   parameter logic [27:0] BANK_SIZE     = 28'h0100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        calib_done,
   input  logic        wr_frame_start,
   input  logic        rd_frame_start,
   input  logic [27:0] addr_max,
   input  logic [10:0] wr_fifo_cnt,
   input  logic [10:0] rd_fifo_cnt,
   output logic        wr_req,
   output logic        rd_req,
   output logic [27:0] req_addr,
   output logic [7:0]  req_len,
   input  logic        req_ack,
   input  logic        burst_done,
   output logic        wr_bank,
   output logic        rd_bank,
   output logic        frame_ready
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;

   localparam logic [27:0] BURST28 = 28'(BURST_LEN);
   localparam logic [7:0]  BURST8  = 8'(BURST_LEN);
   localparam logic [11:0] DEPTH12 = 12'(RD_FIFO_DEPTH);

   state_t      state_q, state_d;
   logic [27:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
   logic [27:0] req_addr_q, req_addr_d;
   logic [7:0]  req_len_q, req_len_d;
   logic        wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic        frame_ready_q, frame_ready_d;
   logic        wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
   logic        last_grant_q, last_grant_d;
   logic        wr_req_q, rd_req_q;

   // Remaining words are computed one bit wider so a shrunken addr_max reads as negative.
   logic [28:0] wr_rem, rd_rem;
   logic [7:0]  wr_len, rd_len;
   logic        wr_avail, rd_avail, wr_elig, rd_elig;
   logic        wr_busy, rd_busy, wr_done, rd_done, wr_apply, rd_apply;

   assign wr_rem   = {1'b0, addr_max} - {1'b0, wr_off_q};
   assign rd_rem   = {1'b0, addr_max} - {1'b0, rd_off_q};
   assign wr_avail = !wr_rem[28] && (wr_rem[27:0] != 28'd0);
   assign rd_avail = !rd_rem[28] && (rd_rem[27:0] != 28'd0);
   assign wr_len   = (wr_rem[27:0] >= BURST28) ? BURST8 : wr_rem[7:0];
   assign rd_len   = (rd_rem[27:0] >= BURST28) ? BURST8 : rd_rem[7:0];
   assign wr_elig  = calib_done && wr_avail && (wr_fifo_cnt >= {3'b000, wr_len});
   assign rd_elig  = calib_done && frame_ready_q && rd_avail &&
                     (({1'b0, rd_fifo_cnt} + {4'b0000, rd_len}) <= DEPTH12);

   assign wr_busy  = (state_q == WR_REQ) || (state_q == WR_WAIT);
   assign rd_busy  = (state_q == RD_REQ) || (state_q == RD_WAIT);
   assign wr_done  = (state_q == WR_WAIT) && burst_done;
   assign rd_done  = (state_q == RD_WAIT) && burst_done;
   assign wr_apply = (wr_frame_start && !wr_busy) || (wr_done && (wr_pend_q || wr_frame_start));
   assign rd_apply = (rd_frame_start && !rd_busy) || (rd_done && (rd_pend_q || rd_frame_start));

   // Grants are held off for a cycle when a frame start lands in IDLE, so a burst never
   // launches from an offset that is being rewound in the same cycle.
   always_comb begin
      state_d       = state_q;
      wr_off_d      = wr_off_q;
      rd_off_d      = rd_off_q;
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      frame_ready_d = frame_ready_q;
      wr_pend_d     = wr_pend_q;
      rd_pend_d     = rd_pend_q;
      last_grant_d  = last_grant_q;
      req_addr_d    = req_addr_q;
      req_len_d     = req_len_q;

      case (state_q)
         IDLE: begin
            if (!wr_frame_start && !rd_frame_start) begin
               if (wr_elig && (!rd_elig || last_grant_q)) begin
                  state_d    = WR_REQ;
                  req_addr_d = (wr_bank_q ? BANK_SIZE : 28'd0) + wr_off_q;
                  req_len_d  = wr_len;
               end else if (rd_elig) begin
                  state_d    = RD_REQ;
                  req_addr_d = (rd_bank_q ? BANK_SIZE : 28'd0) + rd_off_q;
                  req_len_d  = rd_len;
               end
            end
         end
         WR_REQ:  if (req_ack) state_d = WR_WAIT;
         WR_WAIT: if (burst_done) begin
            state_d      = IDLE;
            wr_off_d     = wr_off_q + {20'd0, req_len_q};
            last_grant_d = 1'b0;
         end
         RD_REQ:  if (req_ack) state_d = RD_WAIT;
         RD_WAIT: if (burst_done) begin
            state_d      = IDLE;
            rd_off_d     = rd_off_q + {20'd0, req_len_q};
            last_grant_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // The write frame action resolves before the read one so a simultaneous read start
      // picks up the bank that has just been completed.
      if (wr_apply) begin
         if ((wr_off_d >= addr_max) && (addr_max != 28'd0)) begin
            wr_bank_d     = ~wr_bank_q;
            frame_ready_d = 1'b1;
         end
         wr_off_d  = 28'd0;
         wr_pend_d = 1'b0;
      end else if (wr_frame_start && wr_busy) begin
         wr_pend_d = 1'b1;
      end

      if (rd_apply) begin
         if (frame_ready_d) rd_bank_d = ~wr_bank_d;
         rd_off_d  = 28'd0;
         rd_pend_d = 1'b0;
      end else if (rd_frame_start && rd_busy) begin
         rd_pend_d = 1'b1;
      end
   end

   // last_grant_q high means read was served last, so write wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         wr_off_q      <= 28'd0;
         rd_off_q      <= 28'd0;
         wr_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b0;
         frame_ready_q <= 1'b0;
         wr_pend_q     <= 1'b0;
         rd_pend_q     <= 1'b0;
         last_grant_q  <= 1'b1;
         req_addr_q    <= 28'd0;
         req_len_q     <= 8'd0;
         wr_req_q      <= 1'b0;
         rd_req_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_off_q      <= wr_off_d;
         rd_off_q      <= rd_off_d;
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         frame_ready_q <= frame_ready_d;
         wr_pend_q     <= wr_pend_d;
         rd_pend_q     <= rd_pend_d;
         last_grant_q  <= last_grant_d;
         req_addr_q    <= req_addr_d;
         req_len_q     <= req_len_d;
         wr_req_q      <= (state_d == WR_REQ);
         rd_req_q      <= (state_d == RD_REQ);
      end
   end

   assign wr_req      = wr_req_q;
   assign rd_req      = rd_req_q;
   assign req_addr    = req_addr_q;
   assign req_len     = req_len_q;
   assign wr_bank     = wr_bank_q;
   assign rd_bank     = rd_bank_q;
   assign frame_ready = frame_ready_q;

endmodule
